// File: rtl/sar_ctrl_sync.sv
// Synchronous SAR sequencer: samples, strobes the comparator MSB first, builds SWP/SWN and DOUT; DONE at S+2*N_BITS+1 cycles after START.
// No backpressure: a slow comparator stretches COMPARE up to TIMEOUT_CYCLES, then the bit is forced to 0 and ERR is set.
module sar_ctrl_sync #(
   parameter int N_BITS         = 8,
   parameter int SAMPLE_CYCLES  = 2,
   parameter int TIMEOUT_CYCLES = 4
) (
   input  logic              CLK,
   input  logic              RSTB,
   input  logic              START,
   input  logic              CONT,
   input  logic              CMP_P,
   input  logic              CMP_N,
   output logic              CKSB,
   output logic              CMP_CLK,
   output logic [N_BITS-1:0] SWP,
   output logic [N_BITS-1:0] SWN,
   output logic [N_BITS-1:0] DOUT,
   output logic              DONE,
   output logic              BUSY,
   output logic              ERR
);

   localparam int KW   = (N_BITS > 1) ? $clog2(N_BITS) : 1;
   localparam int CMAX = (SAMPLE_CYCLES > TIMEOUT_CYCLES) ? SAMPLE_CYCLES : TIMEOUT_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [KW-1:0] K_MSB      = KW'(N_BITS - 1);
   localparam logic [KW-1:0] K_ONE      = KW'(1);
   localparam logic [CW-1:0] CNT_SAMPLE = CW'(SAMPLE_CYCLES);
   localparam logic [CW-1:0] CNT_TMO    = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SAMPLE,
      ST_COMPARE,
      ST_RELEASE,
      ST_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [KW-1:0]     k_q, k_d;
   logic [N_BITS-1:0] res_q, res_d;
   logic [N_BITS-1:0] swp_q, swp_d;
   logic [N_BITS-1:0] swn_q, swn_d;
   logic [N_BITS-1:0] dout_q, dout_d;
   logic              err_q, err_d;
   logic              cksb_q, cksb_d;
   logic              cmp_clk_q, cmp_clk_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic              resolved;

   assign resolved = CMP_P ^ CMP_N;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      k_d     = k_q;
      res_d   = res_q;
      swp_d   = swp_q;
      swn_d   = swn_q;
      dout_d  = dout_q;
      err_d   = err_q;

      unique case (state_q)
         ST_IDLE: begin
            if (START) begin
               state_d = ST_SAMPLE;
               cnt_d   = CNT_SAMPLE;
               err_d   = 1'b0;
               res_d   = '0;
            end
         end
         ST_SAMPLE: begin
            if (cnt_q == CNT_ONE) begin
               state_d = ST_COMPARE;
               k_d     = K_MSB;
               cnt_d   = CNT_TMO;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_COMPARE: begin
            if (resolved) begin
               swp_d[k_q] = CMP_P;
               swn_d[k_q] = CMP_N;
               res_d[k_q] = CMP_P;
               state_d    = ST_RELEASE;
            end else if (cnt_q == CNT_ONE) begin
               // Forced decision: treat the stuck comparator as "input below threshold".
               swp_d[k_q] = 1'b0;
               swn_d[k_q] = 1'b1;
               res_d[k_q] = 1'b0;
               err_d      = 1'b1;
               state_d    = ST_RELEASE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_RELEASE: begin
            if (k_q != '0) begin
               k_d     = k_q - K_ONE;
               cnt_d   = CNT_TMO;
               state_d = ST_COMPARE;
            end else begin
               dout_d  = res_q;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (CONT) begin
               state_d = ST_SAMPLE;
               cnt_d   = CNT_SAMPLE;
               err_d   = 1'b0;
               res_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Switch words are held cleared whenever the array is tracking the input.
      if (state_d == ST_IDLE || state_d == ST_SAMPLE) begin
         swp_d = '0;
         swn_d = '0;
      end
   end

   // Phase outputs are decoded from the next state so they are flop outputs aligned with the state.
   always_comb begin
      cksb_d    = (state_d == ST_COMPARE) || (state_d == ST_RELEASE) || (state_d == ST_DONE);
      cmp_clk_d = (state_d == ST_COMPARE);
      done_d    = (state_d == ST_DONE);
      busy_d    = (state_d != ST_IDLE);
   end

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         k_q       <= K_MSB;
         res_q     <= '0;
         swp_q     <= '0;
         swn_q     <= '0;
         dout_q    <= '0;
         err_q     <= 1'b0;
         cksb_q    <= 1'b0;
         cmp_clk_q <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         k_q       <= k_d;
         res_q     <= res_d;
         swp_q     <= swp_d;
         swn_q     <= swn_d;
         dout_q    <= dout_d;
         err_q     <= err_d;
         cksb_q    <= cksb_d;
         cmp_clk_q <= cmp_clk_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   assign CKSB    = cksb_q;
   assign CMP_CLK = cmp_clk_q;
   assign SWP     = swp_q;
   assign SWN     = swn_q;
   assign DOUT    = dout_q;
   assign DONE    = done_q;
   assign BUSY    = busy_q;
   assign ERR     = err_q;

endmodule
